// File: rtl/lsu_ctrl_if.sv
// Request/response and dataMem port bundle for lsu_ctrl.
// The slave modport is the LSU; the master modport is the MEM stage plus dataMem.
interface lsu_ctrl_if #(
    parameter int SIZE = 11
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      funct3;
    logic [31:0]     addr;
    logic [31:0]     store_data;
    logic            resp_valid;
    logic [31:0]     load_data;
    logic            err;
    logic [SIZE-1:0] mem_addr;
    logic            mem_we;
    logic [3:0]      mem_wrType;
    logic [31:0]     mem_dataW;
    logic [31:0]     mem_dataR;

    modport master (
        output req_valid, req_we, funct3, addr, store_data, mem_dataR,
        input  req_ready, resp_valid, load_data, err,
        input  mem_addr, mem_we, mem_wrType, mem_dataW
    );

    modport slave (
        input  req_valid, req_we, funct3, addr, store_data, mem_dataR,
        output req_ready, resp_valid, load_data, err,
        output mem_addr, mem_we, mem_wrType, mem_dataW
    );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store unit: store lane steering, load extraction, optional split of word-crossing accesses.
// Latency: resp_valid 2 cycles after acceptance, 3 for a split access (MISALIGN_SPLIT_EN defined).
// Backpressure: req_ready is high only in IDLE; one access in flight, no response stall.
module lsu_ctrl #(
    parameter int SIZE = 11
) (
    input  logic      clk,
    input  logic      rst,
    lsu_ctrl_if.slave bus
);

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;

    state_t          state;
    logic            rdy_q;
    logic [1:0]      off_q;
    logic [2:0]      f3_q;
    logic            st_q;
    logic            acc_err_q;
    logic            split_q;
    logic [31:0]     hi_dat_q;
    logic [3:0]      hi_lanes_q;
    logic [31:0]     lo_buf;
    logic [SIZE-1:0] mem_addr_q;
    logic            mem_we_q;
    logic [3:0]      mem_wrType_q;
    logic [31:0]     mem_dataW_q;
    logic            resp_valid_q;
    logic [31:0]     load_data_q;
    logic            err_q;

    // request decode, evaluated on the incoming request in IDLE
    logic [1:0]  req_off;
    logic [2:0]  req_n;
    logic [31:0] req_bmask;
    logic [3:0]  req_lane4;
    logic        req_illegal;
    logic        req_misalign;
    logic        req_cross;
    logic        req_err;
    logic        req_split;
    logic        req_store;
    logic [63:0] req_wide;
    logic [7:0]  req_lanes;

    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[31:SIZE+2];

    always_comb begin
        req_off     = bus.addr[1:0];
        req_n       = 3'd1;
        req_bmask   = 32'h0000_00FF;
        req_lane4   = 4'b0001;
        req_illegal = 1'b0;
        case (bus.funct3)
            3'd0, 3'd4: begin
                req_n     = 3'd1;
                req_bmask = 32'h0000_00FF;
                req_lane4 = 4'b0001;
            end
            3'd1, 3'd5: begin
                req_n     = 3'd2;
                req_bmask = 32'h0000_FFFF;
                req_lane4 = 4'b0011;
            end
            3'd2: begin
                req_n     = 3'd4;
                req_bmask = 32'hFFFF_FFFF;
                req_lane4 = 4'b1111;
            end
            default: req_illegal = 1'b1;
        endcase
        // unsigned loads have no store counterpart
        if (bus.funct3[2] && bus.req_we) begin
            req_illegal = 1'b1;
        end
        req_misalign = ((req_n == 3'd2) && req_off[0]) ||
                       ((req_n == 3'd4) && (req_off != 2'd0));
        req_cross    = (3'(req_off) + req_n) > 3'd4;
        req_err      = req_illegal || (!SPLIT_EN && req_misalign);
        req_split    = SPLIT_EN && req_cross && !req_illegal;
        req_store    = bus.req_we && !req_err;
        req_wide     = {32'b0, bus.store_data & req_bmask} << {req_off, 3'b000};
        req_lanes    = {4'b0, req_lane4} << req_off;
    end

    function automatic logic [31:0] extract(input logic [31:0] lo, input logic [31:0] hi,
                                            input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] raw;
        raw = 32'({hi, lo} >> {off, 3'b000});
        case (f3)
            3'd0:    extract = {{24{raw[7]}}, raw[7:0]};
            3'd1:    extract = {{16{raw[15]}}, raw[15:0]};
            3'd2:    extract = raw;
            3'd4:    extract = {24'b0, raw[7:0]};
            3'd5:    extract = {16'b0, raw[15:0]};
            default: extract = 32'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rdy_q        <= 1'b1;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            load_data_q  <= 32'b0;
            mem_we_q     <= 1'b0;
            mem_wrType_q <= 4'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        off_q        <= req_off;
                        f3_q         <= bus.funct3;
                        st_q         <= req_store;
                        acc_err_q    <= req_err;
                        split_q      <= req_split;
                        hi_dat_q     <= req_wide[63:32];
                        hi_lanes_q   <= req_lanes[7:4];
                        mem_addr_q   <= bus.addr[SIZE+1:2];
                        mem_we_q     <= req_store;
                        mem_wrType_q <= req_store ? req_lanes[3:0] : 4'b0;
                        mem_dataW_q  <= req_wide[31:0];
                        rdy_q        <= 1'b0;
                        state        <= ACC_LO;
                    end
                end
                ACC_LO: begin
                    lo_buf <= bus.mem_dataR;
                    if (split_q) begin
                        // word address wraps modulo 2**SIZE at the top of memory
                        mem_addr_q   <= mem_addr_q + {{(SIZE-1){1'b0}}, 1'b1};
                        mem_we_q     <= st_q;
                        mem_wrType_q <= st_q ? hi_lanes_q : 4'b0;
                        mem_dataW_q  <= hi_dat_q;
                        state        <= ACC_HI;
                    end else begin
                        mem_we_q     <= 1'b0;
                        mem_wrType_q <= 4'b0;
                        resp_valid_q <= 1'b1;
                        err_q        <= acc_err_q;
                        load_data_q  <= (acc_err_q || st_q) ? 32'b0
                                      : extract(bus.mem_dataR, 32'b0, off_q, f3_q);
                        state        <= DONE;
                    end
                end
                ACC_HI: begin
                    mem_we_q     <= 1'b0;
                    mem_wrType_q <= 4'b0;
                    resp_valid_q <= 1'b1;
                    err_q        <= acc_err_q;
                    load_data_q  <= (acc_err_q || st_q) ? 32'b0
                                  : extract(lo_buf, bus.mem_dataR, off_q, f3_q);
                    state        <= DONE;
                end
                DONE: begin
                    err_q <= 1'b0;
                    rdy_q <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    rdy_q <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = rdy_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.load_data  = load_data_q;
    assign bus.err        = err_q;
    assign bus.mem_addr   = mem_addr_q;
    // an issued word write is dropped immediately when reset arrives
    assign bus.mem_we     = mem_we_q & ~rst;
    assign bus.mem_wrType = mem_wrType_q;
    assign bus.mem_dataW  = mem_dataW_q;

endmodule
